// File: rtl/pipes.sv
// Shared pipeline types: payload structs carried by stage registers and
// the occupancy encoding used by pipe_stage_reg.
package pipes;

  // Payload of the IF/ID boundary; stages size themselves with $bits().
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  // Stage occupancy: nothing held, main slot held, main + skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic         at_max_s;

  assign at_max_s = (count_r == {W{1'b1}});

  // Step by one on inc unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc && !at_max_s) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered valid/ready pipeline stage. Optional skid slot keeps full
// throughput under backpressure while in_ready stays a pure register, so
// no combinational path crosses the stage in either direction.
module pipe_stage_reg
  import pipes::*;
#(
  parameter int WIDTH      = 64,
  parameter bit SKID       = 1'b1,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_r;
  stage_state_t     state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             ready_r;
  logic             ready_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic             stall_s;

  assign out_valid = (state_r != ST_EMPTY);
  assign out_data  = main_r;
  assign in_ready  = ready_r;

  assign in_hs_s  = in_valid & ready_r;
  assign out_hs_s = out_valid & out_ready;
  assign stall_s  = out_valid & ~out_ready;

  // Next occupancy and payload moves; flush overrides every handshake.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      if (CLEAR_DATA) begin
        main_s = '0;
        skid_s = '0;
      end else begin
        main_s = main_r;
        skid_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_hs_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_hs_s && out_hs_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else if (out_hs_s) begin
            state_s = ST_EMPTY;
          end else if (in_hs_s && SKID) begin
            // Downstream stalled while we were still ready: park in skid.
            state_s = ST_FULL;
            skid_s  = in_data;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_hs_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Ready for next cycle is decided from next occupancy, never from out_ready.
  always_comb begin
    ready_s = 1'b0;
    if (state_s == ST_EMPTY) begin
      ready_s = 1'b1;
    end else if (SKID && (state_s == ST_ONE)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Stage registers; reset empties the stage and holds off upstream one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
      ready_r <= ready_s;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_s),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (two-entry, single-entry on the
// fetch payload, narrow counter) checked against queue-based models.
module tb_pipe_stage_reg;
  import pipes::*;

  localparam int BW = $bits(fetch_data_t);
  localparam longint CA_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint CC_MAX = 64'd15;

  logic clk;
  logic rst_n;

  // instance A: SKID=1, WIDTH=64, CNT_W=32
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [31:0] a_stall;
  // instance B: SKID=0, fetch payload
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BW-1:0] b_in_data, b_out_data;
  logic [31:0]   b_stall;
  // instance C: CNT_W=4, WIDTH=8
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [3:0] c_stall;

  pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .CLEAR_DATA(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_reg #(.WIDTH(BW), .SKID(1'b0), .CLEAR_DATA(1'b1), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .stall_cnt(b_stall));

  pipe_stage_reg #(.WIDTH(8), .SKID(1'b1), .CLEAR_DATA(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .stall_cnt(c_stall));

  // reference models: held entries as FIFOs, ready flag, stall count
  logic [63:0]   qa[$];
  logic [BW-1:0] qb[$];
  logic [7:0]    qc[$];
  bit            ra, rb, rc;
  longint        ca, cb, cc;
  int            sent_b, recv_b;

  int pass_cnt;
  int total_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and apply each stage's rules to the models.
  task automatic tick();
    bit ia, oa, sa, fa, ib, ob, sb, fb, ic, oc, sc, fc;
    logic [63:0]   da;
    logic [BW-1:0] db;
    logic [7:0]    dc;
    ia = a_in_valid && ra; oa = (qa.size() > 0) && a_out_ready;
    sa = (qa.size() > 0) && !a_out_ready; fa = a_flush; da = a_in_data;
    ib = b_in_valid && rb; ob = (qb.size() > 0) && b_out_ready;
    sb = (qb.size() > 0) && !b_out_ready; fb = b_flush; db = b_in_data;
    ic = c_in_valid && rc; oc = (qc.size() > 0) && c_out_ready;
    sc = (qc.size() > 0) && !c_out_ready; fc = c_flush; dc = c_in_data;
    @(posedge clk);
    #1;
    if (fa) qa.delete();
    else begin
      if (oa) void'(qa.pop_front());
      if (ia) qa.push_back(da);
    end
    if (ob) recv_b++;
    if (fb) qb.delete();
    else begin
      if (ob) void'(qb.pop_front());
      if (ib) begin qb.push_back(db); sent_b++; end
    end
    if (fc) qc.delete();
    else begin
      if (oc) void'(qc.pop_front());
      if (ic) qc.push_back(dc);
    end
    ra = (qa.size() < 2);
    rb = (qb.size() < 1);
    rc = (qc.size() < 2);
    if (sa && ca < CA_MAX) ca++;
    if (sb && cb < CA_MAX) cb++;
    if (sc && cc < CC_MAX) cc++;
  endtask

  // Pulse rst_n low between edges and clear the models.
  task automatic pulse_reset();
    #3;
    rst_n = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    ca = 0; cb = 0; cc = 0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic idle_inputs();
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else pass_cnt++;
    total_cnt++;
    if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); else pass_cnt++;
    total_cnt++;
    if (a_out_data !== 64'h0) $display("FAIL reset_out_data: got %h expected 0", a_out_data); else pass_cnt++;
    total_cnt++;
    if (a_stall !== 32'h0) $display("FAIL reset_stall: got %h expected 0", a_stall); else pass_cnt++;
    total_cnt++;
    if (b_out_valid !== 1'b0 || c_stall !== 4'h0)
      $display("FAIL reset_b_c: got b_out_valid=%b c_stall=%h expected 0/0", b_out_valid, c_stall);
    else pass_cnt++;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    total_cnt++;
    if (a_in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b expected 0 before edge", a_in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      $display("FAIL reset_first_edge_ready: got a=%b b=%b expected 1/1", a_in_ready, b_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data = 64'(i);
      total_cnt++;
      if (a_in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", i, a_in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_out_data !== 64'(i))
        $display("FAIL stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, a_out_valid, a_out_data, 64'(i));
      else pass_cnt++;
    end
    a_in_valid = 1'b0;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b0) $display("FAIL stream_drained: got %b expected 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_skid();
    pulse_reset();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hA;
    tick();
    total_cnt++;
    if (a_out_data !== 64'hA || a_in_ready !== 1'b1 || a_stall !== 32'd0)
      $display("FAIL skid_one: got d=%h rdy=%b st=%0d expected d=a rdy=1 st=0", a_out_data, a_in_ready, a_stall);
    else pass_cnt++;
    a_in_data = 64'hB;
    tick();
    total_cnt++;
    if (a_out_data !== 64'hA || a_in_ready !== 1'b0 || a_stall !== 32'd1)
      $display("FAIL skid_full: got d=%h rdy=%b st=%0d expected d=a rdy=0 st=1", a_out_data, a_in_ready, a_stall);
    else pass_cnt++;
    a_in_data = 64'hD;
    tick();
    total_cnt++;
    if (a_out_data !== 64'hA || a_in_ready !== 1'b0 || a_stall !== 32'd2)
      $display("FAIL skid_hold: got d=%h rdy=%b st=%0d expected d=a rdy=0 st=2", a_out_data, a_in_ready, a_stall);
    else pass_cnt++;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_out_data !== 64'hB || a_in_ready !== 1'b1)
      $display("FAIL skid_drain_b: got v=%b d=%h rdy=%b expected v=1 d=b rdy=1", a_out_valid, a_out_data, a_in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_stall !== 32'd2)
      $display("FAIL skid_empty: got v=%b st=%0d expected v=0 st=2", a_out_valid, a_stall);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hA; tick();
    a_in_data = 64'hB; tick();
    a_flush = 1'b1; a_in_data = 64'hC;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_out_data !== 64'h0 || a_in_ready !== 1'b1)
      $display("FAIL flush_squash: got v=%b d=%h rdy=%b expected v=0 d=0 rdy=1", a_out_valid, a_out_data, a_in_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_stall !== ca[31:0]) $display("FAIL flush_keeps_stall: got %0d expected %0d", a_stall, ca[31:0]); else pass_cnt++;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (a_out_valid !== 1'b0) $display("FAIL flush_no_c[%0d]: got v=%b d=%h expected v=0", i, a_out_valid, a_out_data); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h55; tick();
    a_in_valid = 1'b0; tick();
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_stall === 32'd0)
      $display("FAIL areset_setup: got v=%b st=%0d expected v=1 st>0", a_out_valid, a_stall);
    else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_stall !== 32'd0 || a_in_ready !== 1'b0 || a_out_data !== 64'h0)
      $display("FAIL areset_immediate: got v=%b st=%0d rdy=%b d=%h expected 0/0/0/0", a_out_valid, a_stall, a_in_ready, a_out_data);
    else pass_cnt++;
    qa.delete(); qb.delete(); qc.delete();
    ra = 1'b0; rb = 1'b0; rc = 1'b0; ca = 0; cb = 0; cc = 0;
    #2;
    rst_n = 1'b1;
    total_cnt++;
    if (a_in_ready !== 1'b0) $display("FAIL areset_release: got %b expected 0", a_in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL areset_after_edge: got rdy=%b v=%b expected 1/0", a_in_ready, a_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = 8'h3C; tick();
    c_in_valid = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      total_cnt++;
      if (c_stall !== 4'((j > 15) ? 15 : j) || c_stall !== cc[3:0])
        $display("FAIL sat_step[%0d]: got %0d expected %0d", j, c_stall, (j > 15) ? 15 : j);
      else pass_cnt++;
    end
    total_cnt++;
    if (c_stall !== 4'hF || c_out_data !== 8'h3C)
      $display("FAIL sat_final: got st=%h d=%h expected f/3c", c_stall, c_out_data);
    else pass_cnt++;
    c_out_ready = 1'b1;
    tick();
    total_cnt++;
    if (c_stall !== 4'hF || c_out_valid !== 1'b0)
      $display("FAIL sat_drain: got st=%h v=%b expected f/0", c_stall, c_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random_skid0();
    int cycles;
    int errs;
    cycles = 0;
    errs = 0;
    sent_b = 0;
    recv_b = 0;
    while (sent_b < 1000 && cycles < 20000) begin
      b_in_valid = ($urandom_range(0, 3) != 0) && (sent_b + (rb ? 1 : 0) <= 1000);
      b_in_data = {$urandom, $urandom};
      b_out_ready = $urandom_range(0, 1) != 0;
      total_cnt++;
      if (b_out_valid !== (qb.size() > 0) || b_in_ready !== rb ||
          (qb.size() > 0 && b_out_data !== qb[0]) || (b_out_valid && b_in_ready) ||
          b_stall !== cb[31:0]) begin
        if (errs < 10)
          $display("FAIL rand_b[%0d]: got v=%b rdy=%b d=%h st=%0d expected v=%b rdy=%b d=%h st=%0d",
                   cycles, b_out_valid, b_in_ready, b_out_data, b_stall,
                   qb.size() > 0, rb, (qb.size() > 0) ? qb[0] : '0, cb[31:0]);
        errs++;
      end else pass_cnt++;
      tick();
      cycles++;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++;
    if (sent_b != 1000 || recv_b != 1000 || b_out_valid !== 1'b0)
      $display("FAIL rand_b_done: got sent=%0d recv=%0d v=%b expected 1000/1000/0", sent_b, recv_b, b_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random_skid1();
    int errs;
    bit last_flush;
    errs = 0;
    last_flush = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      total_cnt++;
      if (a_out_valid !== (qa.size() > 0) || a_in_ready !== ra ||
          (qa.size() > 0 && a_out_data !== qa[0]) || (last_flush && a_out_data !== 64'h0) ||
          a_stall !== ca[31:0]) begin
        if (errs < 10)
          $display("FAIL rand_a[%0d]: got v=%b rdy=%b d=%h st=%0d expected v=%b rdy=%b d=%h st=%0d",
                   cyc, a_out_valid, a_in_ready, a_out_data, a_stall,
                   qa.size() > 0, ra, (qa.size() > 0) ? qa[0] : 64'h0, ca[31:0]);
        errs++;
      end else pass_cnt++;
      a_in_valid = $urandom_range(0, 2) != 0;
      a_in_data = {$urandom, $urandom};
      a_out_ready = $urandom_range(0, 2) == 0;
      a_flush = $urandom_range(0, 31) == 0;
      last_flush = a_flush;
      tick();
    end
    a_flush = 1'b0;
    a_in_valid = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    idle_inputs();
    qa.delete(); qb.delete(); qc.delete();
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    ca = 0; cb = 0; cc = 0;
    sent_b = 0; recv_b = 0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_saturate();
    test_random_skid0();
    test_random_skid1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits; legal range 1..1024.
REQ-002 Parameter SKID, default 1: 1 = two-entry stage (main + skid slot), full throughput under backpressure; 0 = single-entry stage.
REQ-003 Parameter CLEAR_DATA, default 1: 1 = flush and reset zero the payload registers; 0 = only the valid bits clear.
REQ-004 Parameter CNT_W, default 32, width of the stall counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  synchronous squash of all held entries.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_ready  out  1  stage accepts this cycle.
REQ-010 in_data  in  WIDTH  upstream payload.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 out_data  out  WIDTH  payload presented downstream.
REQ-014 stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-016 State (SKID=1): EMPTY (no entry), ONE (main valid), FULL (main + skid valid); SKID=0 uses EMPTY/ONE only.
REQ-017 in_ready SHALL be a registered signal, not combinationally dependent on out_ready: 1 in EMPTY and ONE when SKID=1; 1 only in EMPTY when SKID=0.
REQ-018 out_valid = main valid; out_data = main payload; no combinational path from in_* to out_*.
REQ-019 Latency: an entry accepted at edge N is visible on out_* after edge N (1-cycle latency).
REQ-020 EMPTY: input handshake -> ONE, data into main.
REQ-021 ONE: input and output handshakes in the same cycle -> stay ONE, main takes new data; output only -> EMPTY; input only -> FULL, data into skid (SKID=1).
REQ-022 FULL: output handshake -> ONE, skid moves to main; in_ready=0, so no input is taken.
REQ-023 Order SHALL be preserved; no entry duplicated or lost except by flush.
REQ-024 Throughput: one entry per cycle sustained while out_ready=1.
REQ-025 flush=1 has highest priority: at the next edge state -> EMPTY regardless of handshakes; an input offered in the flush cycle is dropped; payloads zeroed iff CLEAR_DATA=1.
REQ-026 An output handshake in the flush cycle still counts as delivered (downstream sampled it).
REQ-027 stall_cnt increments by 1 per stall cycle, saturates at all-ones, and is not cleared by flush.

Reset
REQ-028 rst_n=0 asynchronously forces: state EMPTY, out_valid=0, in_ready=0, payload registers 0, stall_cnt=0.
REQ-029 in_ready rises at the first edge after rst_n deasserts; rst_n asserted mid-transfer discards all entries with no partial output.

Structure
REQ-030 Payload struct types (fetch_data_t etc.) stay in package pipes; instances set WIDTH from $bits(type); no new package constants.
REQ-031 One sub-module, sat_counter (parameter W, inc, async active-low reset), implements stall_cnt; the rest is one always_ff plus next-state logic.
REQ-032 The existing IF/ID stage becomes pipe_stage_reg with SKID=0, CLEAR_DATA=1.

Verification
REQ-033 Stream 0x1..0x8 with out_ready=1 constant -> out_data 0x1..0x8 on 8 consecutive cycles, first one 1 cycle after first accept.
REQ-034 SKID=1: accept 0xA, 0xB with out_ready=0 -> FULL, in_ready=0, stall_cnt=1 after first stall cycle; raise out_ready -> 0xA then 0xB, in_ready=1 after 0xA leaves.
REQ-035 FULL with 0xA/0xB, flush=1 and in_valid=1 (0xC) -> next cycle out_valid=0, out_data=0 (CLEAR_DATA=1), 0xC never appears.
REQ-036 rst_n pulsed low mid-cycle while ONE -> out_valid=0 immediately (before next edge), stall_cnt=0, in_ready=0 until first edge after release.
REQ-037 CNT_W=4, 20 stall cycles -> stall_cnt stays at 0xF.
REQ-038 SKID=0, out_ready toggling randomly over 1000 inputs -> in-order delivery against a reference queue, in_ready=0 whenever ONE.
